// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit state encoding and framing constants.
package uart_pkg;

  localparam int   UartDataBits = 8;
  localparam logic IDLE_LEVEL   = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd1,
    TX_DATA  = 3'd2,
    TX_STOP1 = 3'd3,
    TX_STOP2 = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts clocks since the last clear and flags the final
// clock of a bit period (count == divisor), giving div+1 clocks per bit.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_clr,
  input  logic [DIV_WIDTH-1:0] i_div_q,
  output logic                 o_bit_end
);

  logic [DIV_WIDTH-1:0] r_count;

  // Free-running up-counter with synchronous clear at each bit boundary.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + DIV_WIDTH'(1);
    end
  end

  assign o_bit_end = (r_count == i_div_q);

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: accepts a byte on a valid/ready handshake and shifts it
// out as start bit, 8 data bits LSB first, and one or two stop bits.
// Divisor and stop-bit count are captured at accept so mid-frame changes
// only affect the next frame.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UartDataBits,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  tx_en,
  input  logic                  nstop,
  input  logic [DIV_WIDTH-1:0]  div,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  txd,
  output logic                  busy
);

  localparam logic [2:0] LastBit = 3'(DATA_WIDTH - 1);

  tx_state_e             r_state;
  tx_state_e             w_state_nxt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic [DIV_WIDTH-1:0]  r_div_q;
  logic                  r_nstop_q;
  logic [2:0]            r_bit_cnt;
  logic                  r_txd;
  logic                  w_txd_nxt;
  logic                  w_accept;
  logic                  w_cnt_end;
  logic                  w_bit_end;
  logic                  w_cnt_clr;

  assign w_accept  = data_valid & data_ready;
  // The counter's end flag is meaningless in Idle (count parked at zero).
  assign w_bit_end = w_cnt_end & (r_state != TX_IDLE);
  // Hold the counter at zero while idle so Start begins a fresh bit period.
  assign w_cnt_clr = (r_state == TX_IDLE) | w_cnt_end;

  uart_baud_counter #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud (
    .clock     (clock),
    .reset     (reset),
    .i_clr     (w_cnt_clr),
    .i_div_q   (r_div_q),
    .o_bit_end (w_cnt_end)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= TX_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: each non-idle state lasts whole bit periods.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      TX_IDLE:  if (w_accept) w_state_nxt = TX_START;
      TX_START: if (w_bit_end) w_state_nxt = TX_DATA;
      TX_DATA:  if (w_bit_end && (r_bit_cnt == LastBit)) w_state_nxt = TX_STOP1;
      TX_STOP1: if (w_bit_end) w_state_nxt = r_nstop_q ? TX_STOP2 : TX_IDLE;
      TX_STOP2: if (w_bit_end) w_state_nxt = TX_IDLE;
      default:  w_state_nxt = TX_IDLE;
    endcase
  end

  // Outputs: handshake, busy flag and the line level for the next state.
  always_comb begin
    data_ready = (r_state == TX_IDLE) && tx_en && reset;
    busy       = (r_state != TX_IDLE);
    unique case (w_state_nxt)
      TX_START: w_txd_nxt = 1'b0;
      TX_DATA:  w_txd_nxt = w_shift_nxt[0];
      default:  w_txd_nxt = IDLE_LEVEL;
    endcase
  end

  // Shift register next value: load on accept, shift after each data bit.
  always_comb begin
    w_shift_nxt = r_shift;
    if (w_accept) begin
      w_shift_nxt = data_in;
    end else if ((r_state == TX_DATA) && w_bit_end) begin
      w_shift_nxt = r_shift >> 1;
    end
  end

  // Frame datapath: captured config, shifter and data-bit index.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_shift   <= '0;
      r_div_q   <= '0;
      r_nstop_q <= 1'b0;
      r_bit_cnt <= 3'd0;
    end else begin
      r_shift <= w_shift_nxt;
      if (w_accept) begin
        r_div_q   <= div;
        r_nstop_q <= nstop;
        r_bit_cnt <= 3'd0;
      end else if ((r_state == TX_START) && w_bit_end) begin
        r_bit_cnt <= 3'd0;
      end else if ((r_state == TX_DATA) && w_bit_end) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
    end
  end

  // Registered line driver, updated on the same edge as the state change.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_txd <= IDLE_LEVEL;
    end else begin
      r_txd <= w_txd_nxt;
    end
  end

  assign txd = r_txd;

endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
- Standalone serial UART transmitter: takes bytes on a valid/ready handshake and drives the line as start bit, 8 data bits LSB first, then 1 or 2 stop bits.
- Baud rate comes from an internal divisor counter running on the system clock.
- Pairs with the existing receive path (same framing, same div/nstop semantics as the UART register map: baud = f_clock/(div+1)).
- Sits between the tx FIFO read side and the txd pin; also reusable as a bench-side serial driver.

Parameters:
- DATA_WIDTH, 8: bits per frame; fixed to 8 in this revision.
- DIV_WIDTH, 16: width of the baud divisor input.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- tx_en  in  1  transmit enable (txctrl.txen).
- nstop  in  1  0 = one stop bit, 1 = two stop bits.
- div  in  DIV_WIDTH  bit period = div+1 clocks.
- data_in  in  8  byte to send.
- data_valid  in  1  data_in valid.
- data_ready  out  1  core can accept a byte this cycle.
- txd  out  1  serial output, idle high.
- busy  out  1  frame in progress.

Behaviour:
- Reset (asserted, async): state=Idle, txd=1, data_ready=0, busy=0, bit counter=0, tick counter=0, shift register=0. Reset mid-frame aborts the frame immediately; txd returns to 1 without waiting for a clock edge.
- data_ready = (state==Idle) && tx_en && reset deasserted. It is combinational from state and tx_en.
- Accept: on a rising edge with data_valid && data_ready, the core latches:
  - data_in into the shift register;
  - div into div_q;
  - nstop into nstop_q.
  It then enters Start on that same edge. Config changes mid-frame are ignored.
- States are Idle, Start, Data, Stop1, Stop2.
  - Idle: txd=1, busy=0.
  - All other states: busy=1.
- Tick counter:
  - Cleared on entry to each bit state.
  - Increments each clock.
  - The bit ends when it equals div_q, so every bit is exactly div_q+1 clocks. With div_q=0 each bit lasts 1 clock.
- Start: txd=0 for one bit period, then go to Data with bit counter=0.
- Data:
  - txd = shift[0].
  - At bit end: shift right by 1, bit counter +1.
  - After bit counter reaches 7 and that bit ends, go to Stop1. Bit counter is 3 bits and does not wrap mid-frame.
- Stop1: txd=1 for one bit period. At bit end go to Stop2 if nstop_q, else Idle.
- Stop2: txd=1 for one bit period, then go to Idle.
- txd is registered: it changes only on clock edges, 0 cycles after the state transition edge. No glitches.
- Back-to-back frames:
  - The core spends at least 1 clock in Idle between frames.
  - If data_valid is held high, the next byte is accepted on the first Idle edge.
  - Frame period = (1+8+1+nstop)*(div+1) + 1 clocks.
- tx_en deasserted mid-frame: the current frame completes normally, then the core stays Idle with data_ready=0. If data_valid is high while tx_en=0, the byte is not consumed.
- data_valid deasserted before being accepted: nothing happens; there is no protocol error.
- Throughput limit: one byte in flight. The upstream FIFO supplies buffering.

Decomposition:
- Shared package uart_pkg holds:
  - tx state enum (Idle, Start, Data, Stop1, Stop2), encoded 3-bit;
  - localparam UartDataBits=8;
  - IDLE_LEVEL=1'b1.
  The receive path reuses the same enum subset.
- One sub-module, uart_baud_counter. It is a DIV_WIDTH up-counter with sync clear and a bit_end output (count==div_q).
- Everything else lives in uart_tx_core.

Test Plan:
- Reset check: hold reset low 3 clocks, then raise it with tx_en=1 → txd=1, busy=0, data_ready=1 on the first clock after release.
- Single frame: div=3, nstop=0, send 0xA5 → txd holds each of 0,1,0,1,0,0,1,0,1,1 for exactly 4 clocks (40 clocks total); busy falls at clock 40; data_ready high at clock 41.
- Two stop bits, back-to-back: div=1, nstop=1, data_valid held high with 0x3C then 0xC3 → each frame is 22 clocks, with a 1-clock Idle gap; second start bit at clock 23 after the first accept; both bytes sampled LSB first match.
- Config change mid-frame: start 0xFF with div=2, then set div=9 and nstop=1 during Data → current frame keeps 3-clock bits and one stop bit; the next frame uses 10-clock bits and two stop bits.
- tx_en drop: deassert tx_en during bit 4 of 0x55 (div=0) → frame finishes (10 clocks), then data_ready=0 and txd=1 while data_valid=1 is held; the byte is sent only after tx_en returns to 1.
- Reset mid-frame: assert reset during Data of 0x00 → txd=1 asynchronously; after release the state is Idle and no residual bits are sent.
